// File: rtl/iir_fmt_pkg.sv
// rtl/iir_fmt_pkg.sv - Q15.16 sign-magnitude format constants, FSM states and add/negate helpers
package iir_fmt_pkg;

    localparam int SIGN_BIT  = 31;
    localparam int INT_MSB   = 30;
    localparam int FRAC_BITS = 16;
    localparam logic [30:0] MAX_MAG = 31'h7FFF_FFFF;

    typedef enum logic [2:0] {IDLE, FB, SCALE, FF, OUT} state_t;

    // Negation only flips the sign bit; -0 is tolerated and normalised by the adder.
    function automatic logic [31:0] sm_neg(input logic [31:0] v);
        return {~v[SIGN_BIT], v[INT_MSB:0]};
    endfunction

    // Sign-magnitude add. Returns {ovf, result}; zero results always come out as +0.
    function automatic logic [32:0] sm_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic sat);
        logic [31:0] sum;
        logic [30:0] mag;
        logic        sgn;
        logic        ovf;
        sum = '0;
        mag = '0;
        sgn = 1'b0;
        ovf = 1'b0;
        if (a[SIGN_BIT] == b[SIGN_BIT]) begin
            sum = {1'b0, a[INT_MSB:0]} + {1'b0, b[INT_MSB:0]};
            ovf = sum[31];
            sgn = a[SIGN_BIT];
            mag = (ovf && sat) ? MAX_MAG : sum[INT_MSB:0];
        end else if (a[INT_MSB:0] >= b[INT_MSB:0]) begin
            mag = a[INT_MSB:0] - b[INT_MSB:0];
            sgn = a[SIGN_BIT];
        end else begin
            mag = b[INT_MSB:0] - a[INT_MSB:0];
            sgn = b[SIGN_BIT];
        end
        if (mag == '0) begin
            sgn = 1'b0;
        end
        return {ovf, sgn, mag};
    endfunction

endpackage

// File: rtl/sm_q16_mult.sv
// rtl/sm_q16_mult.sv - combinational Q15.16 sign-magnitude multiply with truncation and saturation
module sm_q16_mult
    import iir_fmt_pkg::*;
#(
    parameter int SAT_EN = 1
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p,
    output logic        ovf
);

    logic [61:0] prod;
    logic [30:0] mag;
    logic        unused_frac;

    assign unused_frac = ^prod[FRAC_BITS-1:0];

    // Magnitude product, truncated toward zero; sign dropped when the result is zero.
    always_comb begin
        prod = {31'b0, a[INT_MSB:0]} * {31'b0, b[INT_MSB:0]};
        ovf  = |prod[61:FRAC_BITS+INT_MSB+1];
        mag  = (ovf && (SAT_EN != 0)) ? MAX_MAG : prod[FRAC_BITS+INT_MSB:FRAC_BITS];
        p    = {(a[SIGN_BIT] ^ b[SIGN_BIT]) && (mag != '0), mag};
    end

endmodule

// File: rtl/iir_inverse_equalizer.sv
// rtl/iir_inverse_equalizer.sv - time-multiplexed inverse of the first-order IIR, recovers x from y
module iir_inverse_equalizer
    import iir_fmt_pkg::*;
#(
    parameter int N_BITS = 32,
    parameter int SAT_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic [N_BITS-1:0] y_i,
    input  logic              y_valid_i,
    output logic              y_ready_o,
    input  logic [N_BITS-1:0] inv_b0_i,
    input  logic [N_BITS-1:0] b1_i,
    input  logic [N_BITS-1:0] a_i,
    input  logic [N_BITS-1:0] offset_i,
    output logic [N_BITS-1:0] x_o,
    output logic              x_valid_o,
    input  logic              x_ready_i,
    output logic              ovf_o
);

    localparam logic SAT = (SAT_EN != 0);

    state_t      state;
    logic [31:0] y_r, inv_r, b1_r, a_r, off_r;
    logic [31:0] w1, w0_r, p_r;
    logic [31:0] mul_a, mul_b, mul_p;
    logic        mul_ovf;
    logic [32:0] diff, sum1, sum2;

    sm_q16_mult #(.SAT_EN(SAT_EN)) u_mult (
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p),
        .ovf (mul_ovf)
    );

    // Share the single multiplier across FB/SCALE/FF and form the adder chains around it.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        diff  = sm_add(y_r, sm_neg(p_r), SAT);
        case (state)
            FB:      begin mul_a = b1_r;        mul_b = w1;    end
            SCALE:   begin mul_a = diff[31:0];  mul_b = inv_r; end
            FF:      begin mul_a = a_r;         mul_b = w1;    end
            default: begin mul_a = '0;          mul_b = '0;    end
        endcase
        sum1 = sm_add(w0_r, mul_p, SAT);
        sum2 = sm_add(sum1[31:0], sm_neg(off_r), SAT);
    end

    // Sample FSM: capture, three multiply steps, then hold until the consumer takes x.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            y_r       <= '0;
            inv_r     <= '0;
            b1_r      <= '0;
            a_r       <= '0;
            off_r     <= '0;
            w1        <= '0;
            w0_r      <= '0;
            p_r       <= '0;
            x_o       <= '0;
            x_valid_o <= 1'b0;
            y_ready_o <= 1'b1;
            ovf_o     <= 1'b0;
        end else if (clear_i) begin
            state     <= IDLE;
            w1        <= '0;
            ovf_o     <= 1'b0;
            x_valid_o <= 1'b0;
            y_ready_o <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (y_valid_i && y_ready_o) begin
                        y_r       <= y_i;
                        inv_r     <= inv_b0_i;
                        b1_r      <= b1_i;
                        a_r       <= a_i;
                        off_r     <= offset_i;
                        y_ready_o <= 1'b0;
                        state     <= FB;
                    end
                end
                FB: begin
                    p_r   <= mul_p;
                    ovf_o <= ovf_o | mul_ovf;
                    state <= SCALE;
                end
                SCALE: begin
                    w0_r  <= mul_p;
                    ovf_o <= ovf_o | mul_ovf | diff[32];
                    state <= FF;
                end
                FF: begin
                    x_o       <= sum2[31:0];
                    x_valid_o <= 1'b1;
                    ovf_o     <= ovf_o | mul_ovf | sum1[32] | sum2[32];
                    state     <= OUT;
                end
                OUT: begin
                    if (x_ready_i) begin
                        w1        <= w0_r;
                        x_valid_o <= 1'b0;
                        y_ready_o <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_inverse_equalizer.sv
// tb/tb_iir_inverse_equalizer.sv - directed table-driven bench for iir_inverse_equalizer
module tb_iir_inverse_equalizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_i = 1'b0;
    logic [31:0] y_i = '0;
    logic        y_valid_i = 1'b0;
    logic        y_ready_o;
    logic [31:0] inv_b0_i = '0;
    logic [31:0] b1_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] offset_i = '0;
    logic [31:0] x_o;
    logic        x_valid_o;
    logic        x_ready_i = 1'b1;
    logic        ovf_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] HALF = 32'h0000_8000;

    typedef struct {
        logic        clr;
        logic [31:0] inv;
        logic [31:0] b1;
        logic [31:0] a;
        logic [31:0] off;
        logic [31:0] y;
        logic [31:0] exp_x;
    } vec_t;

    vec_t vecs [8];

    iir_inverse_equalizer #(.N_BITS(32), .SAT_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear_i),
        .y_i       (y_i),
        .y_valid_i (y_valid_i),
        .y_ready_o (y_ready_o),
        .inv_b0_i  (inv_b0_i),
        .b1_i      (b1_i),
        .a_i       (a_i),
        .offset_i  (offset_i),
        .x_o       (x_o),
        .x_valid_o (x_valid_o),
        .x_ready_i (x_ready_i),
        .ovf_o     (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    // Offer one sample; after capture the coefficient inputs are scrambled to prove shadowing.
    task automatic send(input logic [31:0] inv, input logic [31:0] b1, input logic [31:0] a,
                        input logic [31:0] off, input logic [31:0] y);
        int n;
        inv_b0_i  = inv;
        b1_i      = b1;
        a_i       = a;
        offset_i  = off;
        y_i       = y;
        y_valid_i = 1'b1;
        n = 0;
        while (!y_ready_o && n < 50) begin
            step();
            n++;
        end
        chk("send_ready_timeout", {31'b0, y_ready_o}, 32'd1);
        step();
        y_valid_i = 1'b0;
        y_i       = $urandom();
        inv_b0_i  = $urandom();
        b1_i      = $urandom();
        a_i       = $urandom();
        offset_i  = $urandom();
    endtask

    task automatic recv(input string name, input logic [31:0] exp);
        int n;
        x_ready_i = 1'b1;
        n = 0;
        while (!x_valid_o && n < 20) begin
            step();
            n++;
        end
        chk({name, "_valid_timeout"}, {31'b0, x_valid_o}, 32'd1);
        chk(name, x_o, exp);
        step();
    endtask

    initial begin
        vecs[0] = '{1'b1, ONE, 32'h0,  32'h0,  32'h0,         32'h0003_0000, 32'h0003_0000};
        vecs[1] = '{1'b1, ONE, HALF,   HALF,   32'h0,         ONE,           ONE};
        vecs[2] = '{1'b0, ONE, HALF,   HALF,   32'h0,         ONE,           ONE};
        vecs[3] = '{1'b1, ONE, 32'h0,  32'h0,  HALF,          32'h8001_0000, 32'h8001_8000};
        vecs[4] = '{1'b1, ONE, 32'h0,  32'h0,  32'h0,         32'h8000_0000, 32'h0000_0000};
        vecs[5] = '{1'b1, HALF, 32'h0, 32'h0,  32'h0,         32'h8004_0000, 32'h8002_0000};
        vecs[6] = '{1'b1, ONE, 32'h0,  32'h0,  32'h0003_0000, ONE,           32'h8002_0000};
        vecs[7] = '{1'b1, ONE, 32'h0,  32'h0,  ONE,           ONE,           32'h0000_0000};

        // Reset state
        #12;
        chk("rst_x_o", x_o, 32'h0);
        chk("rst_x_valid", {31'b0, x_valid_o}, 32'd0);
        chk("rst_y_ready", {31'b0, y_ready_o}, 32'd1);
        chk("rst_ovf", {31'b0, ovf_o}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].clr) do_clear();
            send(vecs[i].inv, vecs[i].b1, vecs[i].a, vecs[i].off, vecs[i].y);
            recv($sformatf("vec%0d_x", i), vecs[i].exp_x);
            chk($sformatf("vec%0d_ovf", i), {31'b0, ovf_o}, 32'd0);
        end

        // Latency: valid low after the first two edges past acceptance, high after the third
        do_clear();
        x_ready_i = 1'b0;
        send(ONE, 32'h0, 32'h0, 32'h0, 32'h0003_0000);
        chk("lat_e0", {31'b0, x_valid_o}, 32'd0);
        step();
        chk("lat_e1", {31'b0, x_valid_o}, 32'd0);
        step();
        chk("lat_e2", {31'b0, x_valid_o}, 32'd0);
        step();
        chk("lat_e3", {31'b0, x_valid_o}, 32'd1);
        chk("lat_x", x_o, 32'h0003_0000);
        x_ready_i = 1'b1;
        step();
        chk("lat_accept_valid", {31'b0, x_valid_o}, 32'd0);
        chk("lat_accept_ready", {31'b0, y_ready_o}, 32'd1);

        // Backpressure: stalled output, extra sample ignored, w1 updated only on acceptance
        do_clear();
        x_ready_i = 1'b0;
        send(ONE, 32'h0, HALF, 32'h0, 32'h0002_0000);
        for (int n = 0; n < 20 && !x_valid_o; n++) step();
        for (int c = 0; c < 10; c++) begin
            y_valid_i = 1'b1;
            y_i       = 32'h0005_0000;
            chk($sformatf("bp_hold%0d", c), {x_o, x_valid_o, y_ready_o},
                {32'h0002_0000, 1'b1, 1'b0});
            step();
        end
        y_valid_i = 1'b0;
        x_ready_i = 1'b1;
        step();
        send(ONE, 32'h0, HALF, 32'h0, ONE);
        recv("bp_next_x", 32'h0002_0000);

        // Saturation and sticky overflow
        do_clear();
        send(32'h0002_0000, 32'h0, 32'h0, 32'h0, 32'h7000_0000);
        recv("sat_x", 32'h7FFF_FFFF);
        chk("sat_ovf", {31'b0, ovf_o}, 32'd1);
        send(ONE, 32'h0, 32'h0, 32'h0, ONE);
        recv("sat_next_x", ONE);
        chk("sat_ovf_sticky", {31'b0, ovf_o}, 32'd1);
        do_clear();
        chk("sat_ovf_cleared", {31'b0, ovf_o}, 32'd0);

        // Asynchronous reset while in SCALE clears w1 and aborts the sample
        do_clear();
        send(ONE, 32'h0, ONE, 32'h0, 32'h0003_0000);
        recv("rmid_pre_x", 32'h0003_0000);
        send(ONE, 32'h0, ONE, 32'h0, 32'h0002_0000);
        step();
        rst = 1'b1;
        #1;
        chk("rmid_valid", {31'b0, x_valid_o}, 32'd0);
        chk("rmid_ready", {31'b0, y_ready_o}, 32'd1);
        step();
        rst = 1'b0;
        step();
        send(ONE, 32'h0, ONE, 32'h0, ONE);
        recv("rmid_post_x", ONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
